// File: rtl/timer_pkg.sv
// Shared state encoding and width helper for the down_timer block.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;

    // Bits needed to count 0 .. value-1, but never fewer than one.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Prescaler that produces a step every DIV enabled clocks.
module rate_divider
    import timer_pkg::*;
#(
    parameter int DIV = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int               DIV_W  = clog2_min1(DIV);
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_prescaler;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_prescaler <= RELOAD;
        end else if (clear) begin
            r_prescaler <= RELOAD;
        end else if (en) begin
            r_prescaler <= (r_prescaler == '0) ? RELOAD : r_prescaler - 1'b1;
        end
    end

    // Raw terminal count; the owner gates it with its own run state.
    assign tick = (r_prescaler == '0);

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with pause/resume and a one-shot expiry pulse.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             expired,
    output logic             done
);

    timer_state_t     r_state, w_state_next;
    logic [WIDTH-1:0] r_count, w_count_next;
    logic             r_done, w_done_next;
    logic             w_div_tick;
    logic             w_div_en;

    // Prescaler freezes while paused so a resume continues the interrupted period.
    assign w_div_en = (r_state == RUN) && !pause;

    rate_divider #(.DIV(DIV)) u_rate_divider (
        .clock  (clock),
        .resetn (resetn),
        .en     (w_div_en),
        .clear  (load),
        .tick   (w_div_tick)
    );

    assign tick    = w_div_tick && (r_state == RUN);
    assign running = (r_state == RUN);
    assign expired = (r_state == EXPIRED);
    assign count   = r_count;
    assign done    = r_done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_state_next = r_state;
        w_count_next = r_count;
        w_done_next  = 1'b0;
        if (load) begin
            w_state_next = IDLE;
            w_count_next = load_value;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (r_count != '0) begin
                            w_state_next = RUN;
                        end else begin
                            w_state_next = EXPIRED;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Pause beats a coincident step; the count only moves on an unpaused tick.
                    if (pause) begin
                        w_state_next = PAUSED;
                    end else if (tick) begin
                        w_count_next = r_count - 1'b1;
                        if (r_count == WIDTH'(1)) begin
                            w_state_next = EXPIRED;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start) begin
                        w_state_next = RUN;
                    end
                end
                EXPIRED: begin
                    w_state_next = EXPIRED;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: two instances (DIV=4 and DIV=1) with directed vectors.
module tb_down_timer;

    typedef struct {
        int         cyc;
        int         dut;
        string      name;
        logic [7:0] count;
        logic       tick;
        logic       running;
        logic       expired;
        logic       done;
    } exp_t;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;

    logic       load_a = 1'b0, start_a = 1'b0, pause_a = 1'b0;
    logic [7:0] load_value_a = 8'h00;
    logic [7:0] count_a;
    logic       tick_a, running_a, expired_a, done_a;

    logic       load_b = 1'b0, start_b = 1'b0, pause_b = 1'b0;
    logic [7:0] load_value_b = 8'h00;
    logic [7:0] count_b;
    logic       tick_b, running_b, expired_b, done_b;

    down_timer #(.WIDTH(8), .DIV(4)) dut_a (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load_a),
        .load_value (load_value_a),
        .start      (start_a),
        .pause      (pause_a),
        .count      (count_a),
        .tick       (tick_a),
        .running    (running_a),
        .expired    (expired_a),
        .done       (done_a)
    );

    down_timer #(.WIDTH(8), .DIV(1)) dut_b (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load_b),
        .load_value (load_value_b),
        .start      (start_b),
        .pause      (pause_b),
        .count      (count_b),
        .tick       (tick_b),
        .running    (running_b),
        .expired    (expired_b),
        .done       (done_b)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event async_ev;

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        exp_t        e;
        logic [11:0] got;
        logic [11:0] want;
        forever begin
            @(negedge clock or async_ev);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)", e.name, e.cyc, cyc);
                end else begin
                    got  = (e.dut == 0) ? {count_a, tick_a, running_a, expired_a, done_a}
                                        : {count_b, tick_b, running_b, expired_b, done_b};
                    want = {e.count, e.tick, e.running, e.expired, e.done};
                    if (got === want) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s (cycle %0d, dut %0d): got count=%02h tick=%b running=%b expired=%b done=%b, expected count=%02h tick=%b running=%b expired=%b done=%b",
                                 e.name, cyc, e.dut, got[11:4], got[3], got[2], got[1], got[0],
                                 want[11:4], want[3], want[2], want[1], want[0]);
                    end
                end
            end
        end
    end

    task automatic push(input int dut, input string nm, input int at_cyc,
                        input logic [7:0] c, input bit t, input bit r, input bit e, input bit d);
        exp_t x;
        x.cyc = at_cyc; x.dut = dut; x.name = nm;
        x.count = c; x.tick = t; x.running = r; x.expired = e; x.done = d;
        sb.push_back(x);
    endtask

    // Drive one cycle of inputs and expect the outputs seen after the next rising edge.
    task automatic vec(input int dut, input string nm,
                       input bit ld, input logic [7:0] lv, input bit st, input bit pa,
                       input logic [7:0] c, input bit t, input bit r, input bit e, input bit d);
        if (dut == 0) begin
            load_a = ld; load_value_a = lv; start_a = st; pause_a = pa;
        end else begin
            load_b = ld; load_value_b = lv; start_b = st; pause_b = pa;
        end
        push(dut, nm, cyc + 1, c, t, r, e, d);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clock);
        vec(0, "reset_a", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(1, "reset_b", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        resetn = 1'b1;

        // Basic countdown from 3: steps at E+4, E+8, E+12.
        vec(0, "cd_load", 1, 8'd3, 0, 0, 8'd3, 0, 0, 0, 0);
        for (int m = 0; m < 14; m++) begin
            vec(0, "cd_run", 0, 8'h00, (m == 0), 0,
                (m < 12) ? 8'(3 - m / 4) : 8'd0,
                (m < 12) && (m % 4 == 3), (m < 12), (m >= 12), (m == 12));
        end
        vec(0, "cd_start_ignored", 0, 8'h00, 1, 0, 8'd0, 0, 0, 1, 0);

        // Pause/resume: paused cycles excluded; start wins over pause at resume.
        vec(0, "pr_load", 1, 8'd5, 0, 0, 8'd5, 0, 0, 0, 0);
        for (int m = 0; m < 16; m++) begin
            vec(0, "pr_run", 0, 8'h00, (m == 0) || (m == 12), (m >= 2) && (m <= 12),
                (m < 15) ? 8'd5 : 8'd4, (m == 14), !((m >= 2) && (m <= 11)), 0, 0);
        end

        // Load beats start in RUN and reloads the prescaler.
        vec(0, "lp_load9",     1, 8'd9,  0, 0, 8'd9,  0, 0, 0, 0);
        vec(0, "lp_run",       0, 8'h00, 1, 0, 8'd9,  0, 1, 0, 0);
        vec(0, "lp_run",       0, 8'h00, 0, 0, 8'd9,  0, 1, 0, 0);
        vec(0, "lp_run",       0, 8'h00, 0, 0, 8'd9,  0, 1, 0, 0);
        vec(0, "lp_load_wins", 1, 8'hA0, 1, 0, 8'hA0, 0, 0, 0, 0);
        for (int m = 0; m < 5; m++) begin
            vec(0, "lp_prescaler", 0, 8'h00, (m == 0), 0,
                (m < 4) ? 8'hA0 : 8'h9F, (m == 3), 1, 0, 0);
        end

        // Zero load expires at once with no tick.
        vec(0, "z_load0", 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, "z_start", 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1);
        vec(0, "z_hold",  0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0);

        // Asynchronous reset in the middle of a run.
        vec(0, "rst_load", 1, 8'h37, 0, 0, 8'h37, 0, 0, 0, 0);
        vec(0, "rst_run",  0, 8'h00, 1, 0, 8'h37, 0, 1, 0, 0);
        vec(0, "rst_run",  0, 8'h00, 0, 0, 8'h37, 0, 1, 0, 0);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        push(0, "rst_async", cyc, 8'h00, 0, 0, 0, 0);
        -> async_ev;
        @(negedge clock);
        resetn = 1'b1;
        vec(0, "rst_idle",       0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, "rst_idle_start", 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1);

        // DIV=1: one step per clock, no wrap, start ignored once expired.
        vec(1, "b_load", 1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, 0);
        for (int m = 0; m < 258; m++) begin
            vec(1, "b_run", 0, 8'h00, (m == 0) || (m == 257), 0,
                (m < 255) ? 8'(255 - m) : 8'd0, (m < 255), (m < 255), (m >= 255), (m == 255));
        end
        vec(1, "b_reload", 1, 8'h10, 0, 0, 8'h10, 0, 0, 0, 0);

        @(negedge clock);
        @(negedge clock);
        while (sb.size() > 0) begin
            exp_t left;
            left = sb.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", left.name, left.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counter timer. It is the counting-down counterpart to the team's 8-bit enable-driven up-counter.
- A built-in rate divider produces a step tick every DIV clocks. The count decrements on each tick until it reaches zero, then the timer stops in an expired state.
- Used as the countdown/timeout source for lab display and control logic, for example HEX readout of `count`.

Parameters:
- WIDTH, 8, width of the count register and `load_value`.
- DIV, 50000000, clock cycles per count step. Legal range 1 .. 2^26. DIV=1 means one step per clock.
- DIV_W, $clog2(DIV) with a minimum of 1, width of the prescaler (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value captured on `load`.
- start  in  1  start or resume request (level sampled each clock).
- pause  in  1  pause request (level sampled each clock).
- count  out  WIDTH  current count value.
- tick  out  1  combinational; high in the RUN cycle where a step occurs.
- running  out  1  high while the state is RUN.
- expired  out  1  high while the state is EXPIRED.
- done  out  1  registered one-cycle pulse on entry to EXPIRED.

Behaviour:
- Reset is decided: reset resetn, asynchronous, active-low; clock clock.
- Reset values: state=IDLE, count=0, prescaler=DIV-1, done=0. Therefore tick=0, running=0, expired=0.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: holding mid-count.
  - EXPIRED: count reached 0.
- Priority on each edge: load > start/pause > counting.
- load, in any state including RUN, PAUSED and EXPIRED:
  - count <= load_value, prescaler <= DIV-1, state <= IDLE, done <= 0.
  - start and pause are ignored in the same cycle.
- IDLE:
  - start with count != 0 → RUN.
  - start with count == 0 → EXPIRED, done pulses.
  - pause is ignored.
- RUN:
  - tick = (prescaler == 0).
  - On a tick edge: prescaler <= DIV-1 and count <= count-1.
  - Otherwise: prescaler <= prescaler-1.
  - If a tick occurs with count == 1: count <= 0, state <= EXPIRED, done <= 1 for the next cycle only.
  - pause (with no load): state <= PAUSED. The prescaler and count hold, and no decrement occurs that cycle even if tick is high. Pause wins over the tick and over start.
- PAUSED:
  - start → RUN. The prescaler resumes from its held value, so no partial period is lost or added.
  - pause alone holds the state. When start and pause are both high, start wins.
- EXPIRED:
  - count stays 0. start and pause are ignored. Only load or reset leaves this state.
- Latency: with start sampled at edge E from IDLE, the first decrement occurs at edge E+DIV and each further decrement every DIV edges. From a load of N followed by start, EXPIRED is entered at edge E+N*DIV.
- Count never wraps: there is no decrement below 0.
- load_value=0 followed by start expires immediately, per the IDLE rule.
- done is exactly one cycle wide. It is never asserted outside the first EXPIRED cycle.
- Reset mid-RUN: all state returns to reset values immediately (asynchronously). The first clock after release sees IDLE.
- Arithmetic: all unsigned. The prescaler is DIV_W bits and compares against DIV-1 sized to DIV_W.

Decomposition:
- timer_pkg holds:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSED, EXPIRED};
  - the $clog2-with-minimum-1 helper constant function.
- One sub-module, rate_divider, containing the prescaler:
  - Inputs: clock, resetn, en, clear.
  - Output: tick.
  - Parameter: DIV.
  - en = (state == RUN) && !pause.
  - clear = load.
  - tick is combinational from the prescaler value gated by state==RUN.
- down_timer holds the FSM, the count register and the done register.

Test Plan:
- Use WIDTH=8, DIV=4 unless a line says otherwise.
- Reset during activity: assert resetn=0 mid-RUN with count=0x37 → count=0, running=0, expired=0 and done=0 immediately, without waiting for a clock edge. After release, state is IDLE.
- Basic countdown: load 3, then start for 1 cycle at edge E → count becomes 2, 1, 0 at edges E+4, E+8, E+12. tick is high in the cycles before those edges. expired rises and done pulses exactly once after edge E+12.
- Pause/resume: load 5, start, pause for 10 cycles starting 2 cycles after start, then start → count stays 5 during the pause. The first decrement occurs 4 RUN cycles after start in total, with paused cycles excluded.
- Load priority: in RUN with count=9, assert load=1, load_value=0xA0, and start=1 together → next cycle count=0xA0, state IDLE, running=0, prescaler=3.
- Zero and edge values: load 0 then start → expired and a done pulse on the next cycle, with no tick. Separately, with DIV=1, load 0xFF then start → count decrements every clock and expires after 255 edges without wrapping. After that, start has no effect until load.
